// File: rtl/nand_pkg.sv
// Shared types and parameter defaults for the NAND operand feeder stage.
package nand_pkg;

    // Default operand/result width; must match the nand_gate port width.
    localparam int NAND_WIDTH = 4;
    // Default number of operand FIFO entries (power of two, >= 2).
    localparam int NAND_DEPTH = 4;
    // Default width of the completed-operation counter.
    localparam int NAND_CNT_W = 8;

    // One buffered operand pair. It is held in the FIFO until the output
    // register consumes it.
    typedef struct packed {
        logic [NAND_WIDTH-1:0] a;
        logic [NAND_WIDTH-1:0] b;
    } nand_op_t;

endpackage

// File: rtl/nand_feed_pipe_if.sv
// Bundle of the handshake and data signals around nand_feed_pipe.
//
// Handshake rule for both in_* and out_*: a transfer happens on a rising
// clk edge where valid && ready are both 1. A sender holds valid and data
// stable until that edge. ready may be 1 with valid low; nothing moves then.
// The op_* group is a plain combinational loop through the external nand_gate.
interface nand_feed_pipe_if #(
    parameter int WIDTH = nand_pkg::NAND_WIDTH,
    parameter int CNT_W = nand_pkg::NAND_CNT_W
);
    // Operand input channel
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    // Loop through the external nand_gate
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_y;

    // Result output channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;

    // Number of results accepted downstream (wrapping)
    logic [CNT_W-1:0] done_cnt;

    // Stage side
    modport slave (
        input  in_valid, in_a, in_b, op_y, out_ready,
        output in_ready, op_a, op_b, out_valid, out_y, out_a, out_b, done_cnt
    );

    // Environment side: producer, nand_gate and consumer
    modport master (
        output in_valid, in_a, in_b, op_y, out_ready,
        input  in_ready, op_a, op_b, out_valid, out_y, out_a, out_b, done_cnt
    );

endinterface

// File: rtl/nand_op_fifo.sv
// Small synchronous FIFO of operand pairs. The head entry is visible
// combinationally so it can feed the nand_gate without an extra cycle.
module nand_op_fifo
    import nand_pkg::*;
#(
    parameter int DEPTH = NAND_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  nand_op_t push_data,
    input  logic     pop,
    output nand_op_t head,
    output logic     full,
    output logic     empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    // Storage is never reset; its contents only matter where count says so.
    nand_op_t mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

    // A push into a full FIFO or a pop from an empty one is ignored, so
    // an accepted entry is never overwritten and the pointers stay in step.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Empty FIFO presents zeros so the downstream gate sees a defined input.
    assign head = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointer and occupancy values. DEPTH is a power of two, so the
    // pointers wrap modulo DEPTH through plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared immediately by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Write the accepted pair into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/nand_feed_pipe.sv
// Operand feeder and result-capture stage around an external 4-bit
// nand_gate. Operand pairs queue in a FIFO whose head drives the gate. Each
// result is latched together with its operands into an output register with
// its own handshake. Results accepted downstream are counted.
module nand_feed_pipe
    import nand_pkg::*;
#(
    parameter int WIDTH = NAND_WIDTH,
    parameter int DEPTH = NAND_DEPTH,
    parameter int CNT_W = NAND_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    nand_feed_pipe_if.slave bus
);

    // FIFO connections
    nand_op_t fifo_in;
    nand_op_t fifo_head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     push;
    logic     load;
    logic     accept;
    logic     in_ready;

    // Output register and counter state
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_y_q, out_y_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

    // in_ready looks only at FIFO occupancy, never at out_ready. A full
    // FIFO therefore refuses a pair even in a cycle where it also pops.
    // While rst is high the stage accepts nothing.
    assign in_ready = !rst && !fifo_full;
    assign push     = bus.in_valid && in_ready;

    // The register reloads whenever it is empty or is being emptied this
    // cycle. Accept and reload in the same cycle leave no bubble.
    assign load   = !fifo_empty && (!out_valid_q || bus.out_ready);
    assign accept = out_valid_q && bus.out_ready;

    // Pack the offered operands into a FIFO entry.
    always_comb begin
        fifo_in   = '0;
        fifo_in.a = bus.in_a;
        fifo_in.b = bus.in_b;
    end

    nand_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_in),
        .pop       (load),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next state of the result register and the completion counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        done_cnt_d  = done_cnt_q;
        if (load) begin
            // op_y is only ever sampled here, with a non-empty FIFO head.
            out_valid_d = 1'b1;
            out_y_d     = bus.op_y;
            out_a_d     = fifo_head.a;
            out_b_d     = fifo_head.b;
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            done_cnt_d = done_cnt_q + 1'b1;
        end
    end

    // Result register and counter, cleared immediately by rst. A pending
    // result is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            done_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    // Drive the bus.
    assign bus.in_ready  = in_ready;
    assign bus.op_a      = fifo_head.a;
    assign bus.op_b      = fifo_head.b;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_nand_feed_pipe.sv
// Testbench for nand_feed_pipe. A stand-in for nand_gate closes the op loop.
// The reference model tracks buffered pairs, output-register occupancy and a
// queue of expected {a, b, ~(a & b)} results.
module tb_nand_feed_pipe;
    import nand_pkg::*;

    localparam int W  = NAND_WIDTH;
    localparam int D  = NAND_DEPTH;
    localparam int CW = NAND_CNT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nand_feed_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    // Behaves like the external nand_gate.
    assign bus.op_y = ~(bus.op_a & bus.op_b);

    nand_feed_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [3*W-1:0] exp_q[$];
    int             n_cmp  = 0;
    int             n_fail = 0;
    int             fifo_n = 0;     // pairs accepted but not yet in out reg
    bit             reg_full = 1'b0;
    logic [CW-1:0]  exp_done = '0;
    bit             hold_v = 1'b0;
    logic [3*W-1:0] hold_val;
    bit             push_m, load_m;
    logic [3*W-1:0] head_exp;
    bit             rnd_run;

    function void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    function logic [3*W-1:0] result_of(input logic [W-1:0] a, input logic [W-1:0] b);
        return {a, b, ~(a & b)};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_in_ready", 32'(bus.in_ready), 32'd0);
            check("rst_done_cnt", 32'(bus.done_cnt), 32'd0);
            check("rst_out_data", 32'({bus.out_a, bus.out_b, bus.out_y}), 32'd0);
            exp_q.delete();
            fifo_n   = 0;
            reg_full = 1'b0;
            exp_done = '0;
            hold_v   = 1'b0;
        end else begin
            check("in_ready", 32'(bus.in_ready), 32'(fifo_n != D));
            check("out_valid", 32'(bus.out_valid), 32'(reg_full));
            check("done_cnt", 32'(bus.done_cnt), 32'(exp_done));
            if (fifo_n == 0) begin
                check("op_zero", 32'({bus.op_a, bus.op_b}), 32'd0);
            end else if (exp_q.size() > (reg_full ? 1 : 0)) begin
                head_exp = exp_q[reg_full ? 1 : 0];
                check("op_head", 32'({bus.op_a, bus.op_b}), 32'(head_exp[3*W-1:W]));
            end
            if (hold_v) begin
                check("hold_stable", 32'({bus.out_a, bus.out_b, bus.out_y}), 32'(hold_val));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL result: got %h expected nothing (stale) at %0t",
                             {bus.out_a, bus.out_b, bus.out_y}, $time);
                end else begin
                    check("result", 32'({bus.out_a, bus.out_b, bus.out_y}), 32'(exp_q.pop_front()));
                end
                exp_done = exp_done + 1'b1;
            end
            hold_v   = bus.out_valid && !bus.out_ready;
            hold_val = {bus.out_a, bus.out_b, bus.out_y};
            // Model the coming edge.
            push_m = bus.in_valid && (fifo_n != D);
            load_m = (fifo_n > 0) && (!reg_full || bus.out_ready);
            if (push_m) exp_q.push_back(result_of(bus.in_a, bus.in_b));
            fifo_n = fifo_n + (push_m ? 1 : 0) - (load_m ? 1 : 0);
            if (load_m) reg_full = 1'b1;
            else if (reg_full && bus.out_ready) reg_full = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the pair was taken.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)));
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || reg_full) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0 || reg_full) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single pair, consumer ready.
        bus.out_ready = 1'b1;
        send(4'b0010, 4'b0010);
        wait_drain();

        // Back-to-back pairs, no bubble expected.
        send(4'b0100, 4'b1000);
        send(4'b1100, 4'b1111);
        wait_drain();

        // Consumer stalled: one in the register, DEPTH in the FIFO, the
        // next pair waits until the consumer resumes.
        bus.out_ready = 1'b0;
        for (int i = 0; i < D + 1; i++) send_rand();
        fork
            send_rand();
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        wait_drain();

        // Asynchronous reset with buffered pairs and a pending result.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_rand();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("async_rst_done_cnt", 32'(bus.done_cnt), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        send_rand();
        send_rand();
        wait_drain();

        // Long random run, crosses the done_cnt wrap.
        rnd_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 260; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send_rand();
                end
                wait_drain();
                rnd_run = 1'b0;
            end
            begin
                while (rnd_run) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nand_feed_pipe.md
Name: nand_feed_pipe

Overview:
Buffered operand feeder and result-capture stage wrapped around the 4-bit combinational nand_gate.
- Upstream producers push {A,B} operand pairs through a valid/ready handshake into a small FIFO.
- The FIFO head drives the nand_gate inputs directly.
- The returned Y is registered together with its operands into an output register with its own valid/ready handshake.
- The stage decouples operand producers from result consumers and counts completed operations.

Parameters:
WIDTH, 4, operand/result bit width; must match nand_gate port width.
DEPTH, 4, operand FIFO entries; power of two, >= 2.
CNT_W, 8, width of completed-operation counter.

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair offered
in_ready  output  1  stage can accept operand pair
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
op_a  output  WIDTH  to nand_gate .A (FIFO head A)
op_b  output  WIDTH  to nand_gate .B (FIFO head B)
op_y  input  WIDTH  from nand_gate .Y
out_valid  output  1  result register holds valid result
out_ready  input  1  consumer accepts result
out_y  output  WIDTH  registered NAND result
out_a  output  WIDTH  registered operand A of that result
out_b  output  WIDTH  registered operand B of that result
done_cnt  output  CNT_W  number of results accepted downstream

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- On rst assertion, without waiting for clk:
  - FIFO write pointer, read pointer and count all go to 0.
  - out_valid=0, out_y/out_a/out_b=0, done_cnt=0.
  - FIFO storage contents are don't-care.
- in_ready = !rst && (count != DEPTH). in_ready is 0 while rst is high.
- push = in_valid && in_ready.
  - Writes {in_a,in_b} at wr_ptr; wr_ptr increments modulo DEPTH.
  - in_valid without in_ready is ignored. The producer must hold its data, and the stage never drops an accepted pair.
- op_a/op_b = FIFO head entry when count>0, else all-zero.
  - The stage never inspects op_y when count==0.
- load = (count>0) && (!out_valid || out_ready).
  - On load: out_a<=op_a, out_b<=op_b, out_y<=op_y, out_valid<=1.
  - The FIFO pops: rd_ptr increments modulo DEPTH.
- out_valid clears when out_valid && out_ready && !load.
  - When the consumer accepts and a new head is available in the same cycle, the register reloads back-to-back with no bubble.
- Holding: while out_valid && !out_ready, out_* remain stable.
- done_cnt increments on each out_valid && out_ready edge. It wraps (2^CNT_W)-1 -> 0.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Full: in_ready=0 even if a pop occurs in the same cycle. There is no ready pass-through, so in_ready never depends combinationally on out_ready.
- Empty with simultaneous push: no bypass. Entry becomes head after the edge.
- Latency: pair accepted at edge N -> out_valid=1 after edge N+1 (minimum 2 cycles in-to-out).
- Throughput: 1 result/cycle when in_valid and out_ready are held high.
- Reset mid-operation: all buffered pairs and any pending result are discarded. Operation resumes cleanly after rst deasserts.
- Pointers use ADDR_W = clog2(DEPTH) bits. count uses ADDR_W+1 bits.

Decomposition:
- Package nand_pkg:
  - NAND_WIDTH=4, NAND_DEPTH=4, NAND_CNT_W=8 (parameter defaults)
  - packed struct typedef nand_op_t {a, b}, used for FIFO entries
- Sub-module nand_op_fifo:
  - Synchronous FIFO of nand_op_t with count, full/empty, push/pop, head output.
  - Same clk/rst.
- Top level contains the output register, load/handshake logic and done_cnt. It instantiates nand_op_fifo.
- nand_gate is instantiated outside this block by the integrating level.

Test Plan:
1. Reset, then push a=0010,b=0010 with out_ready=1 -> out_valid high one edge after acceptance; out_y=1101, out_a=0010, out_b=0010; done_cnt=1.
2. Back-to-back pushes of (0100,1000), (1100,1111) with out_ready=1 -> consecutive cycles out_y=1111 then 0011; no bubble; done_cnt +2.
3. Hold out_ready=0, push 5 pairs -> first loads the output register, next 4 fill the FIFO, in_ready=0. Sixth in_valid is held off. out_y stays at first result until out_ready rises. Then the remaining 4 drain in order.
4. Full FIFO with out_ready=1 and in_valid=1 in the same cycle -> no push that cycle (in_ready=0); push accepted the following cycle; count never exceeds DEPTH.
5. Assert rst asynchronously (mid-clock) with 3 entries buffered and out_valid=1 -> out_valid=0, done_cnt=0, in_ready=0 immediately. After release, in_ready=1 and no stale results appear.
6. Drive 256 accepted results -> done_cnt wraps 255 -> 0; data ordering correct throughout.
